serial_adder_ctrl: RTL

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/serial_adder_ctrl_full_adder.sv | 16 +
 rtl/serial_adder_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared FSM state type and width default for the serial adder
package serial_adder_pkg;

  // Operand width used when the instantiating block does not override it.
  localparam int WIDTH_DEFAULT = 8;

  // Controller states: waiting, shifting one bit per clock, result just loaded.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// rtl/serial_adder_ctrl_full_adder.sv - 1-bit full-adder cell used as the serial bit slice
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Plain combinational sum and majority carry.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller, LSB first; SERIAL_ADD_OVF_EN adds the ovf output
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  // Holds the low WIDTH-1 sum bits; the MSB comes straight from the slice on the last edge.
  logic [WIDTH-2:0] res_sh;
  logic [WIDTH-2:0] res_next;
  logic             fa_s;
  logic             fa_co;

  full_adder u_slice (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bits enter the result register from the MSB end and move toward bit 0.
  generate
    if (WIDTH == 2) begin : g_res_one
      assign res_next = fa_s;
    end else begin : g_res_many
      assign res_next = {fa_s, res_sh[WIDTH-2:1]};
    end
  endgenerate

  // Controller FSM: capture operands, shift one bit per clock, load the result in one step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      cnt    <= '0;
      carry  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_co;
          res_sh <= res_next;
          if (cnt == LAST) begin
            sum   <= {fa_s, res_sh};
            cout  <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
            // carry register still holds the carry into the MSB on this edge
            ovf   <= carry ^ fa_co;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
